// File: rtl/pulse_period_meter.sv
// Measures cycles between successive rising edges of Pulse, with sticky timeout.
// Optional running min/max of measured periods when PERIOD_METER_MINMAX_EN is defined.
module pulse_period_meter #(
  parameter  int MAX_PERIOD = 1024,
  localparam int W          = $clog2(MAX_PERIOD + 1)
) (
  input  logic         ClockIn,
  input  logic         reset,
  input  logic         Pulse,
  input  logic         Clear,
  output logic [W-1:0] Period,
  output logic         Valid,
  output logic         Timeout
`ifdef PERIOD_METER_MINMAX_EN
  ,
  output logic [W-1:0] MinPeriod,
  output logic [W-1:0] MaxPeriod
`endif
);

  // state   | meaning
  // IDLE    | not armed, counter held at 0, waiting for first edge
  // MEASURE | armed, counting cycles since the last edge
  typedef enum logic {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } state_t;

  localparam logic [W-1:0] CNT_MAX = W'(MAX_PERIOD);
  localparam logic [W-1:0] CNT_ONE = W'(1);

  state_t       state_q, state_d;
  logic [W-1:0] count_q, count_d;
  logic [W-1:0] period_q, period_d;
  logic         valid_q, valid_d;
  logic         timeout_q, timeout_d;
  logic         pulse_q;
  logic         edge_det;

`ifdef PERIOD_METER_MINMAX_EN
  logic [W-1:0] min_q, min_d;
  logic [W-1:0] max_q, max_d;
`endif

  assign edge_det = Pulse & ~pulse_q;

  always_ff @(posedge ClockIn) begin
    if (reset) begin
      state_q   <= IDLE;
      count_q   <= '0;
      period_q  <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      pulse_q   <= 1'b0;
`ifdef PERIOD_METER_MINMAX_EN
      min_q     <= '1;
      max_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      period_q  <= period_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
      pulse_q   <= Pulse;
`ifdef PERIOD_METER_MINMAX_EN
      min_q     <= min_d;
      max_q     <= max_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    period_d  = period_q;
    valid_d   = 1'b0;
    timeout_d = timeout_q;
`ifdef PERIOD_METER_MINMAX_EN
    min_d     = min_q;
    max_d     = max_q;
`endif

    // Clear wins over a coincident edge; that edge is dropped, not used to arm.
    if (Clear) begin
      state_d   = IDLE;
      count_d   = '0;
      period_d  = '0;
      timeout_d = 1'b0;
`ifdef PERIOD_METER_MINMAX_EN
      min_d     = '1;
      max_d     = '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          count_d = '0;
          if (edge_det) begin
            count_d = CNT_ONE;
            state_d = MEASURE;
          end
        end
        MEASURE: begin
          if (edge_det) begin
            period_d  = count_q;
            valid_d   = 1'b1;
            timeout_d = 1'b0;
            count_d   = CNT_ONE;
`ifdef PERIOD_METER_MINMAX_EN
            if (count_q < min_q) min_d = count_q;
            if (count_q > max_q) max_d = count_q;
`endif
          end else if (count_q == CNT_MAX) begin
            timeout_d = 1'b1;
            state_d   = IDLE;
            count_d   = '0;
          end else begin
            count_d = count_q + CNT_ONE;
          end
        end
        default: begin
          state_d = IDLE;
          count_d = '0;
        end
      endcase
    end
  end

  assign Period  = period_q;
  assign Valid   = valid_q;
  assign Timeout = timeout_q;
`ifdef PERIOD_METER_MINMAX_EN
  assign MinPeriod = min_q;
  assign MaxPeriod = max_q;
`endif

endmodule

// File: doc/pulse_period_meter.md
# pulse_period_meter

Measures the spacing of a periodic one-cycle pulse train, the inverse of the rate divider. It counts `ClockIn` cycles between successive rising edges of `Pulse` and reports the measured period with a one-cycle valid strobe. It flags a timeout when pulses stop arriving. It sits in the tetris helper modules and monitors divider-generated enables, such as gravity ticks and input-repeat ticks, so that debug logic and assertions can confirm tick rates at runtime.

## Interface
- `MAX_PERIOD`, default 1024 — longest measurable period in cycles; localparam `W = $clog2(MAX_PERIOD+1)`.
- `ClockIn` — in, 1 — single clock; all logic on posedge.
- `reset` — in, 1 — synchronous, active-high reset.
- `Pulse` — in, 1 — monitored signal, synchronous to `ClockIn`; only rising edges count.
- `Clear` — in, 1 — synchronous soft clear of measurement state.
- `Period` — out, W — last measured edge-to-edge spacing, in cycles.
- `Valid` — out, 1 — one-cycle strobe; `Period` was updated this cycle.
- `Timeout` — out, 1 — sticky; no edge within `MAX_PERIOD` cycles.
- `MinPeriod`, `MaxPeriod` — out, W each — present only with `PERIOD_METER_MINMAX_EN`.

## Operation
- Edge detect: `edge = Pulse & ~pulse_q`, where `pulse_q` is `Pulse` registered.
  - A level held high counts as one edge.
  - Back-to-back high cycles do not re-trigger.
- State machine has two states.
- **IDLE**: the counter holds 0.
  - On `edge`, the counter loads 1 and the state moves to MEASURE.
  - No `Valid` is produced; the first edge only arms the meter.
- **MEASURE**: the counter increments by 1 each cycle.
  - On `edge`: `Period <= count`, `Valid <= 1`, `Timeout <= 0`, counter reloads to 1, state stays MEASURE.
  - When `count == MAX_PERIOD` and there is no edge: `Timeout <= 1`, state moves to IDLE, counter goes to 0. `Period` is retained.
  - An edge in the same cycle as `count == MAX_PERIOD` is a valid measurement with `Period = MAX_PERIOD` and no timeout.
- Counter arithmetic:
  - The counter never exceeds `MAX_PERIOD`; no wrap-around is possible.
  - The minimum reportable period is 1, which occurs when edges are 1 cycle apart. Because of edge detection this requires `Pulse` to go low in between, so the practical minimum is 2.
- **Clear**:
  - State goes to IDLE, counter to 0, `Period` to 0, `Valid` to 0, `Timeout` to 0.
  - `pulse_q` still updates from `Pulse`.
  - Clear takes priority over a simultaneous edge; that edge is discarded and does not arm the meter.
- **Reset**: same as Clear, and additionally `pulse_q <= 0`.
  - A `Pulse` that is high in the first cycle after reset is therefore seen as an edge.
  - Reset mid-measurement discards the partial count.

## Timing
- Reset values:
  - `Period = 0`, `Valid = 0`, `Timeout = 0`.
  - State IDLE, counter 0, `pulse_q = 0`.
  - `MinPeriod = {W{1'b1}}`, `MaxPeriod = 0`.
- All outputs are registered.
- `Valid` and `Period` appear 1 cycle after the cycle in which the closing edge is sampled.
- `Valid` is high for exactly one cycle per measurement.
- `Timeout` rises 1 cycle after the sampling edge at which `count == MAX_PERIOD`.
  - It remains high until the next `Valid`, `Clear`, or `reset`.
  - It is not cleared by re-arming in IDLE.
- `Period` is stable between `Valid` strobes.

## Configuration
- `PERIOD_METER_MINMAX_EN` defined:
  - Adds the `MinPeriod` and `MaxPeriod` ports.
  - On every `Valid`, `MinPeriod <= min(MinPeriod, new)` and `MaxPeriod <= max(MaxPeriod, new)`, updated in the same cycle as `Period`.
  - `Clear` and `reset` restore all-ones and 0 respectively.
  - Timeouts do not update these registers.
- Not defined: the ports and registers are absent; all other behaviour is identical.

## Test plan
- **Steady train.** Drive `Pulse` with a 1-cycle pulse every 4 cycles.
  - The first edge produces no `Valid`.
  - Each subsequent `Valid` carries `Period = 4`, with `Valid` 1 cycle after each edge.
  - `Timeout` stays 0.
- **Held level.** Hold `Pulse` high for 3 cycles, low for 5, and repeat.
  - Expect `Period = 8`.
  - Expect no extra `Valid` during the high phase.
- **Timeout boundary.** With `MAX_PERIOD = 16`:
  - An edge spacing of 16 gives `Valid` with `Period = 16` and `Timeout = 0`.
  - A spacing of 17 gives `Timeout = 1` and no `Valid`.
  - The next two edges, 5 apart, give `Period = 5` and drop `Timeout`.
- **Clear collision.** Assert `Clear` in the same cycle as a closing edge.
  - Expect no `Valid`, with `Period = 0`, `Timeout = 0`, and state IDLE.
  - The next edge only arms the meter.
- **Reset mid-measurement.** Assert `reset` 3 cycles into a 10-cycle interval.
  - All outputs return to reset values.
  - The following edges, 10 apart, give `Period = 10`.
- **Min/max (with `PERIOD_METER_MINMAX_EN`).** Use edge spacings of 6, 3, 9.
  - `MinPeriod` sequence: 6, 3, 3.
  - `MaxPeriod` sequence: 6, 6, 9.
  - After `Clear`, `MinPeriod` returns to all-ones and `MaxPeriod` to 0.
